// File: rtl/jtframe_romrq_pkg.sv
// Shared types and constants for the romrq SDRAM-side arbiter.
package jtframe_romrq_pkg;

   // Arbiter sequence: pick a client, request the bank, stream the burst, let the last word land
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DATA  = 2'd2,
      ST_FLUSH = 2'd3
   } arb_state_t;

   // Each grant moves one 32-bit value as two 16-bit SDRAM words
   localparam int BURST_WORDS = 2;

   // Index width for an N-entry client vector; never collapses to zero bits
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational winner selection: first asserted request at or after a base index,
// wrapping from N-1 back to 0. A base of zero gives plain fixed priority.
module jtframe_rr_pick
   import jtframe_romrq_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan the request vector starting at base; the first hit wins
   always_comb begin
      int k;
      logic [IW-1:0] kk;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      k     = 0;
      kk    = '0;
      for (int i = 0; i < N; i++) begin
         k = int'(base) + i;
         if (k >= N) k = k - N;
         kk = IW'(k);
         if (!any && req[kk]) begin
            any       = 1'b1;
            grant[kk] = 1'b1;
            idx       = kk;
         end
      end
   end

endmodule

// File: rtl/jtframe_romrq_arb.sv
// SDRAM-side responder for N romrq clients: arbitrates requests, issues one two-word
// burst per grant on the bank port and returns the data on a shared bus with a
// one-hot per-client write strobe.
module jtframe_romrq_arb
   import jtframe_romrq_pkg::*;
#(
   parameter int SDRAMW = 22,
   parameter int N      = 4,
   parameter int RR     = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        slot_req,
   input  logic [N*SDRAMW-1:0] slot_addr,
   output logic [N-1:0]        slot_we,
   output logic [15:0]         din,
   output logic                din_ok,
   output logic                dst,
   output logic                ba_rd,
   output logic [SDRAMW-1:0]   ba_addr,
   input  logic                ba_ack,
   input  logic                ba_dst,
   input  logic                ba_dok,
   input  logic                ba_rdy,
   input  logic [15:0]         sdram_din
);

   localparam int IW = idx_w(N);

   arb_state_t        state_q, state_d;
   logic              ba_rd_q, ba_rd_d;
   logic [SDRAMW-1:0] ba_addr_q, ba_addr_d;
   logic [IW-1:0]     sel_q, sel_d;
   logic [N-1:0]      sel_oh_q, sel_oh_d;
   logic [N-1:0]      we_q, we_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [15:0]       din_q, din_d;
   logic              din_ok_q, din_ok_d;
   logic              dst_q, dst_d;

   logic [IW-1:0]     pick_base;
   logic [N-1:0]      pick_grant;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;

   // Fixed priority simply scans from slot 0 every time
   assign pick_base = (RR != 0) ? ptr_q : '0;

   // The client currently owning the bus is masked so its stale req cannot re-win
   jtframe_rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (slot_req & ~we_q),
      .base  (pick_base),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Next-state and next-output computation for the grant/request/data/flush sequence
   always_comb begin
      state_d   = state_q;
      ba_rd_d   = ba_rd_q;
      ba_addr_d = ba_addr_q;
      sel_d     = sel_q;
      sel_oh_d  = sel_oh_q;
      we_d      = we_q;
      ptr_d     = ptr_q;
      din_d     = din_q;
      din_ok_d  = 1'b0;
      dst_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               sel_d     = pick_idx;
               sel_oh_d  = pick_grant;
               ba_addr_d = slot_addr[pick_idx*SDRAMW +: SDRAMW];
               ba_rd_d   = 1'b1;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ba_ack) begin
               ba_rd_d = 1'b0;
               we_d    = sel_oh_q;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            din_d    = sdram_din;
            din_ok_d = ba_dok;
            dst_d    = ba_dst;
            if (ba_rdy) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            we_d    = '0;
            ptr_d   = (sel_q == IW'(N-1)) ? '0 : sel_q + IW'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any burst in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ba_rd_q   <= 1'b0;
         ba_addr_q <= '0;
         sel_q     <= '0;
         sel_oh_q  <= '0;
         we_q      <= '0;
         ptr_q     <= '0;
         din_q     <= '0;
         din_ok_q  <= 1'b0;
         dst_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ba_rd_q   <= ba_rd_d;
         ba_addr_q <= ba_addr_d;
         sel_q     <= sel_d;
         sel_oh_q  <= sel_oh_d;
         we_q      <= we_d;
         ptr_q     <= ptr_d;
         din_q     <= din_d;
         din_ok_q  <= din_ok_d;
         dst_q     <= dst_d;
      end
   end

   assign slot_we = we_q;
   assign din     = din_q;
   assign din_ok  = din_ok_q;
   assign dst     = dst_q;
   assign ba_rd   = ba_rd_q;
   assign ba_addr = ba_addr_q;

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Bench for jtframe_romrq_arb: a fixed-priority and a round-robin instance, one bank
// model serving whichever is requesting, client models latching bursts, and a
// scoreboard of expected grants/data filled when requests are raised.
module tb_jtframe_romrq_arb;
   import jtframe_romrq_pkg::*;

   localparam int N  = 4;
   localparam int AW = 22;

   typedef struct {
      int          dut;
      int          slot;
      logic [AW-1:0] addr;
      logic [31:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*AW-1:0] slot_addr;
   logic [N-1:0]    slot_req  [2];
   logic [N-1:0]    slot_we   [2];
   logic [15:0]     din       [2];
   logic            din_ok    [2];
   logic            dst       [2];
   logic            ba_rd     [2];
   logic [AW-1:0]   ba_addr   [2];
   logic            ba_ack    [2];
   logic            ba_dst    [2];
   logic            ba_dok    [2];
   logic            ba_rdy    [2];
   logic [15:0]     sdram_din [2];

   logic [AW-1:0]   addr_tab [N];
   int              iss  [2][N];
   int              done [2][N];
   exp_t            sb[$];
   int              errors = 0;
   int              checks = 0;

   int              ack_dly = 2;
   int              gap     = 1;
   bit              single  = 1'b0;

   always #5 clk = ~clk;

   jtframe_romrq_arb #(.SDRAMW(AW), .N(N), .RR(0)) u_fix (
      .clk(clk), .rst(rst), .slot_req(slot_req[0]), .slot_addr(slot_addr),
      .slot_we(slot_we[0]), .din(din[0]), .din_ok(din_ok[0]), .dst(dst[0]),
      .ba_rd(ba_rd[0]), .ba_addr(ba_addr[0]), .ba_ack(ba_ack[0]), .ba_dst(ba_dst[0]),
      .ba_dok(ba_dok[0]), .ba_rdy(ba_rdy[0]), .sdram_din(sdram_din[0])
   );

   jtframe_romrq_arb #(.SDRAMW(AW), .N(N), .RR(1)) u_rr (
      .clk(clk), .rst(rst), .slot_req(slot_req[1]), .slot_addr(slot_addr),
      .slot_we(slot_we[1]), .din(din[1]), .din_ok(din_ok[1]), .dst(dst[1]),
      .ba_rd(ba_rd[1]), .ba_addr(ba_addr[1]), .ba_ack(ba_ack[1]), .ba_dst(ba_dst[1]),
      .ba_dok(ba_dok[1]), .ba_rdy(ba_rdy[1]), .sdram_din(sdram_din[1])
   );

   // A client keeps requesting while it has outstanding refills
   always_comb begin
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < N; k++)
            slot_req[d][k] = (iss[d][k] != done[d][k]);
   end

   function automatic logic [15:0] bank_word(input logic [AW-1:0] a, input int k);
      if (k == 0) return a[15:0] ^ 16'h5A5A;
      return {a[7:0], a[15:8]} ^ 16'h0F0F;
   endfunction

   function automatic int oh2idx(input logic [N-1:0] v);
      int r = -1;
      for (int k = 0; k < N; k++) if (v[k]) r = k;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_burst(input int d, input int s, input bit partial);
      exp_t e;
      e.dut  = d;
      e.slot = s;
      e.addr = addr_tab[s];
      e.data = partial ? {16'h0000, bank_word(addr_tab[s], 0)}
                       : {bank_word(addr_tab[s], 1), bank_word(addr_tab[s], 0)};
      sb.push_back(e);
   endtask

   task automatic req(input int d, input int s, input int cnt);
      iss[d][s] = iss[d][s] + cnt;
   endtask

   task automatic complete(input int d, input int s, input logic [31:0] data);
      if (sb.size() == 0) begin
         chk("unexpected_burst", 64'd1, 64'd0);
      end else begin
         exp_t e = sb.pop_front();
         chk("burst_dut", 64'(e.dut == d), 64'd1);
         chk("burst_slot", 64'(s), 64'(e.slot));
         chk("burst_data", 64'(data), 64'(e.data));
      end
      if (s >= 0) done[d][s] = done[d][s] + 1;
   endtask

   task automatic wait_done(input int d, input int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sb.size() == 0 && slot_we[d] == '0 && !ba_rd[d]) && n < lim);
      chk("done_timeout", 64'(n >= lim), 64'd0);
   endtask

   // Bank model: ack after ack_dly, word0 with dst three cycles later, word1 with rdy after gap
   task automatic bank_serve(input int d);
      logic [AW-1:0] a = ba_addr[d];
      repeat (ack_dly) @(negedge clk);
      ba_ack[d] = 1'b1;
      @(negedge clk);
      ba_ack[d] = 1'b0;
      repeat (2) @(negedge clk);
      ba_dst[d]    = 1'b1;
      ba_dok[d]    = 1'b1;
      ba_rdy[d]    = single;
      sdram_din[d] = bank_word(a, 0);
      @(negedge clk);
      ba_dst[d] = 1'b0;
      ba_dok[d] = 1'b0;
      ba_rdy[d] = 1'b0;
      if (!single) begin
         repeat (gap - 1) @(negedge clk);
         ba_dok[d]    = 1'b1;
         ba_rdy[d]    = 1'b1;
         sdram_din[d] = bank_word(a, 1);
         @(negedge clk);
         ba_dok[d] = 1'b0;
         ba_rdy[d] = 1'b0;
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         ba_ack[d] = 1'b0; ba_dst[d] = 1'b0; ba_dok[d] = 1'b0; ba_rdy[d] = 1'b0;
         sdram_din[d] = 16'h0000;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++)
            if (ba_rd[d] && !rst) bank_serve(d);
      end
   end

   // Client models and per-cycle protocol checks on both instances
   initial begin
      logic [N-1:0] prev_we [2];
      bit           have0   [2];
      logic [15:0]  w0      [2];
      logic [N-1:0] we_s, exp_oh;
      for (int d = 0; d < 2; d++) begin
         prev_we[d] = '0; have0[d] = 1'b0; w0[d] = 16'h0;
         for (int k = 0; k < N; k++) done[d][k] = 0;
      end
      @(negedge clk);
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            we_s = slot_we[d];
            chk("we_onehot", 64'($onehot0(we_s)), 64'd1);
            chk("ok_gated", 64'(din_ok[d] && we_s == '0), 64'd0);
            chk("dst_gated", 64'(dst[d] && we_s == '0), 64'd0);
            if (ba_rd[d]) begin
               if (sb.size() == 0) begin
                  chk("spurious_rd", 64'd1, 64'd0);
               end else begin
                  chk("rd_addr", 64'(ba_addr[d]), 64'(sb[0].addr));
                  chk("rd_we_low", 64'(we_s), 64'd0);
               end
            end
            if (we_s != '0 && prev_we[d] == '0 && sb.size() != 0) begin
               for (int k = 0; k < N; k++) exp_oh[k] = (k == sb[0].slot);
               chk("we_slot", 64'(we_s), 64'(exp_oh));
            end
            if (we_s != '0 && dst[d] && din_ok[d]) begin
               have0[d] = 1'b1;
               w0[d]    = din[d];
            end else if (we_s != '0 && din_ok[d] && have0[d]) begin
               complete(d, oh2idx(we_s), {din[d], w0[d]});
               have0[d] = 1'b0;
            end else if (we_s == '0 && prev_we[d] != '0 && have0[d]) begin
               complete(d, oh2idx(prev_we[d]), {16'h0000, w0[d]});
               have0[d] = 1'b0;
            end
            prev_we[d] = we_s;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   // Directed sequence
   initial begin
      int  rdc;
      bit  hit;
      logic [N-1:0] pw;
      addr_tab[0] = 22'h3F0A2;
      addr_tab[1] = 22'h00100;
      addr_tab[2] = 22'h2ABCD;
      addr_tab[3] = 22'h15555;
      for (int k = 0; k < N; k++) slot_addr[k*AW +: AW] = addr_tab[k];
      for (int d = 0; d < 2; d++) for (int k = 0; k < N; k++) iss[d][k] = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ba_rd", 64'(ba_rd[0]), 64'd0);
      chk("rst_ba_addr", 64'(ba_addr[0]), 64'd0);
      chk("rst_slot_we", 64'(slot_we[0]), 64'd0);
      chk("rst_din", 64'(din[0]), 64'd0);
      chk("rst_din_ok", 64'(din_ok[0]), 64'd0);
      chk("rst_dst", 64'(dst[0]), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single client, slot 1
      expect_burst(0, 1, 1'b0);
      req(0, 1, 1);
      @(negedge clk);
      chk("t1_rd_latency", 64'(ba_rd[0]), 64'd1);
      chk("t1_addr", 64'(ba_addr[0]), 64'h00100);
      wait_done(0, 200);

      // Fixed priority: slots 0 and 2 together, slot 2 granted as soon as we drops
      expect_burst(0, 0, 1'b0);
      expect_burst(0, 2, 1'b0);
      req(0, 0, 1);
      req(0, 2, 1);
      pw  = '0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pw != '0 && slot_we[0] == '0) begin
            hit = 1'b1;
            break;
         end
         pw = slot_we[0];
      end
      chk("t2_we_fall_seen", 64'(hit), 64'd1);
      chk("t2_eval_cycle_rd", 64'(ba_rd[0]), 64'd0);
      @(negedge clk);
      chk("t2_turnaround_rd", 64'(ba_rd[0]), 64'd1);
      chk("t2_turnaround_addr", 64'(ba_addr[0]), 64'(addr_tab[2]));
      wait_done(0, 200);

      // Round-robin: serve slot 0 so the pointer sits at 1, then 0 and 2 -> 2 first
      expect_burst(1, 0, 1'b0);
      req(1, 0, 1);
      wait_done(1, 200);
      expect_burst(1, 2, 1'b0);
      expect_burst(1, 0, 1'b0);
      req(1, 0, 1);
      req(1, 2, 1);
      wait_done(1, 300);

      // Round-robin fairness: pointer back to 0 via slot 3, then all four twice
      expect_burst(1, 3, 1'b0);
      req(1, 3, 1);
      wait_done(1, 200);
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < N; s++) expect_burst(1, s, 1'b0);
      for (int s = 0; s < N; s++) req(1, s, 2);
      wait_done(1, 800);

      // Reset in the middle of a burst, word1 arriving late after reset
      gap = 2;
      expect_burst(0, 1, 1'b1);
      req(0, 1, 1);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dst[0]) begin
            hit = 1'b1;
            break;
         end
      end
      chk("t4_word0_seen", 64'(hit), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_ba_rd", 64'(ba_rd[0]), 64'd0);
      chk("t4_ba_addr", 64'(ba_addr[0]), 64'd0);
      chk("t4_slot_we", 64'(slot_we[0]), 64'd0);
      chk("t4_din", 64'(din[0]), 64'd0);
      chk("t4_din_ok", 64'(din_ok[0]), 64'd0);
      chk("t4_dst", 64'(dst[0]), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t4_late_ok_ignored", 64'(din_ok[0]), 64'd0);
      chk("t4_late_rd_none", 64'(ba_rd[0]), 64'd0);
      wait_done(0, 200);
      gap = 1;
      expect_burst(0, 3, 1'b0);
      req(0, 3, 1);
      wait_done(0, 200);

      // Slow acknowledge: request held for the whole wait
      ack_dly = 10;
      expect_burst(0, 2, 1'b0);
      req(0, 2, 1);
      rdc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (slot_we[0] != '0) break;
         if (ba_rd[0]) rdc++;
      end
      chk("t5_rd_cycles", 64'(rdc), 64'd11);
      wait_done(0, 200);

      // Single-word controller with immediate ack
      ack_dly = 0;
      single  = 1'b1;
      expect_burst(0, 0, 1'b1);
      req(0, 0, 1);
      rdc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (slot_we[0] != '0) break;
         if (ba_rd[0]) rdc++;
      end
      chk("t6_rd_cycles", 64'(rdc), 64'd1);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (dst[0]) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("t6_dst_seen", 64'(hit), 64'd1);
      chk("t6_ok_with_dst", 64'(din_ok[0]), 64'd1);
      chk("t6_word0", 64'(din[0]), 64'(bank_word(addr_tab[0], 0)));
      @(negedge clk);
      chk("t6_idle_we", 64'(slot_we[0]), 64'd0);
      chk("t6_single_dst", 64'(dst[0]), 64'd0);
      chk("t6_idle_ok", 64'(din_ok[0]), 64'd0);
      wait_done(0, 200);
      single  = 1'b0;
      ack_dly = 2;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
